// File: rtl/mux_pipe_if.sv
// Handshake bundle for mux_pipe: upstream beat (data, select, valid/ready), downstream beat, error flag.
interface mux_pipe_if #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1
);
    logic [WIDTH*CHANNELS-1:0] in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      sel_err;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );
endinterface

// File: rtl/mux_pipe.sv
// Channel-select mux with a two-entry skid pipeline; MUX_PIPE_SEL_CHECK_EN enables out-of-range select flagging.
// Latency: one cycle from accept to out_valid.
// Backpressure: in_ready is the registered inverse of skid occupancy, so out_ready never reaches it combinationally.
module mux_pipe #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_pipe_if.slave     bus
);
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] skid_q;
    logic             out_v;
    logic             skid_v;
    logic [WIDTH-1:0] pick;
    logic             sel_bad;
    logic             accept;
    logic             emit;

    assign accept        = bus.in_valid & ~skid_v;
    assign emit          = out_v & bus.out_ready;
    assign bus.in_ready  = ~skid_v;
    assign bus.out_data  = out_q;
    assign bus.out_valid = out_v;

    always_comb begin
        pick = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!sel_bad && (32'(bus.in_sel) == k))
                pick = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            out_v  <= 1'b0;
            skid_q <= '0;
            skid_v <= 1'b0;
        end else if (emit) begin
            // Skid drains first; it is only occupied while in_ready is low, so no accept can race it.
            if (skid_v) begin
                out_q  <= skid_q;
                skid_v <= 1'b0;
            end else if (accept) begin
                out_q  <= pick;
            end else begin
                out_v  <= 1'b0;
            end
        end else if (accept) begin
            if (out_v) begin
                skid_q <= pick;
                skid_v <= 1'b1;
            end else begin
                out_q  <= pick;
                out_v  <= 1'b1;
            end
        end
    end

`ifdef MUX_PIPE_SEL_CHECK_EN
    logic sel_err_q;

    assign sel_bad     = (32'(bus.in_sel) >= CHANNELS);
    assign bus.sel_err = sel_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sel_err_q <= 1'b0;
        else if (accept && sel_bad)
            sel_err_q <= 1'b1;
    end
`else
    assign sel_bad     = 1'b0;
    assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe.sv
// Directed bench for mux_pipe: latency, skid backpressure, full throughput, async reset, select checking.
module tb_mux_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_pipe_if #(.WIDTH(5), .CHANNELS(2), .SEL_W(1)) i2 ();
    mux_pipe_if #(.WIDTH(5), .CHANNELS(4), .SEL_W(2)) i4 ();
    mux_pipe_if #(.WIDTH(5), .CHANNELS(3), .SEL_W(2)) i3 ();

    mux_pipe #(.WIDTH(5), .CHANNELS(2), .SEL_W(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));
    mux_pipe #(.WIDTH(5), .CHANNELS(4), .SEL_W(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));
    mux_pipe #(.WIDTH(5), .CHANNELS(3), .SEL_W(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (i2.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid2 got %b want 0", i2.out_valid); end
        checks++; if (i2.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready2 got %b want 1", i2.in_ready); end
        checks++; if (i2.out_data !== 5'h00) begin errors++; $display("FAIL rst_out_data2 got %h want 00", i2.out_data); end
        checks++; if (i4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid4 got %b want 0", i4.out_valid); end
        checks++; if (i3.sel_err !== 1'b0) begin errors++; $display("FAIL rst_sel_err got %b want 0", i3.sel_err); end
    endtask

    task automatic test_basic();
        i2.out_ready = 1'b1;
        i2.in_data   = {5'h15, 5'h0A};
        i2.in_sel    = 1'b1;
        i2.in_valid  = 1'b1;
        checks++; if (i2.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_first got %b want 1", i2.in_ready); end
        checks++; if (i2.out_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid got %b want 0", i2.out_valid); end
        tick();
        checks++; if (i2.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", i2.out_valid); end
        checks++; if (i2.out_data !== 5'h15) begin errors++; $display("FAIL basic_sel1 got %h want 15", i2.out_data); end
        i2.in_sel = 1'b0;
        tick();
        checks++; if (i2.out_data !== 5'h0A) begin errors++; $display("FAIL basic_sel0 got %h want 0a", i2.out_data); end
        i2.in_valid = 1'b0;
        tick();
        checks++; if (i2.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", i2.out_valid); end
    endtask

    task automatic test_stall();
        i4.out_ready = 1'b0;
        i4.in_data   = {5'h04, 5'h03, 5'h02, 5'h01};
        i4.in_sel    = 2'd0;
        i4.in_valid  = 1'b1;
        tick();
        checks++; if (i4.out_data !== 5'h01 || i4.out_valid !== 1'b1) begin errors++; $display("FAIL stall_a got %h/%b want 01/1", i4.out_data, i4.out_valid); end
        checks++; if (i4.in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_a got %b want 1", i4.in_ready); end
        i4.in_sel = 2'd1;
        tick();
        checks++; if (i4.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_b got %b want 0", i4.in_ready); end
        checks++; if (i4.out_data !== 5'h01) begin errors++; $display("FAIL stall_hold_b got %h want 01", i4.out_data); end
        // Third beat offered while full; ch1 data changed to show the skid copy is not overwritten.
        i4.in_sel  = 2'd2;
        i4.in_data = {5'h04, 5'h03, 5'h1F, 5'h01};
        tick();
        checks++; if (i4.in_ready !== 1'b0 || i4.out_data !== 5'h01) begin errors++; $display("FAIL stall_hold_c got %b/%h want 0/01", i4.in_ready, i4.out_data); end
        i4.out_ready = 1'b1;
        tick();
        checks++; if (i4.out_data !== 5'h02 || i4.out_valid !== 1'b1) begin errors++; $display("FAIL stall_emit_b got %h/%b want 02/1", i4.out_data, i4.out_valid); end
        checks++; if (i4.in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_back got %b want 1", i4.in_ready); end
        tick();
        checks++; if (i4.out_data !== 5'h03 || i4.out_valid !== 1'b1) begin errors++; $display("FAIL stall_emit_c got %h/%b want 03/1", i4.out_data, i4.out_valid); end
        i4.in_valid = 1'b0;
        tick();
        checks++; if (i4.out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %b want 0", i4.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        i4.out_ready = 1'b1;
        i4.in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) i4.in_data[k*5 +: 5] = 5'(i*3 + k*7);
            i4.in_sel = 2'(i % 4);
            exp = 5'(i*3 + (i % 4)*7);
            tick();
            checks++; if (i4.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got %b want 1", i, i4.out_valid); end
            checks++; if (i4.out_data !== exp) begin errors++; $display("FAIL b2b_data beat %0d got %h want %h", i, i4.out_data, exp); end
            checks++; if (i4.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready beat %0d got %b want 1", i, i4.in_ready); end
        end
        i4.in_valid = 1'b0;
        tick();
        checks++; if (i4.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", i4.out_valid); end
    endtask

    task automatic test_async_reset();
        i4.out_ready = 1'b0;
        i4.in_data   = {5'h1E, 5'h03, 5'h02, 5'h11};
        i4.in_sel    = 2'd3;
        i4.in_valid  = 1'b1;
        tick();
        i4.in_sel = 2'd0;
        tick();
        checks++; if (i4.in_ready !== 1'b0 || i4.out_valid !== 1'b1 || i4.out_data !== 5'h1E) begin errors++; $display("FAIL arst_full got %b/%b/%h want 0/1/1e", i4.in_ready, i4.out_valid, i4.out_data); end
        i4.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (i4.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", i4.out_valid); end
        checks++; if (i4.in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b want 1", i4.in_ready); end
        checks++; if (i4.out_data !== 5'h00) begin errors++; $display("FAIL arst_data got %h want 00", i4.out_data); end
        #2 rst_n = 1'b1;
        i4.out_ready = 1'b1;
        i4.in_sel    = 2'd2;
        i4.in_valid  = 1'b1;
        tick();
        checks++; if (i4.out_valid !== 1'b1 || i4.out_data !== 5'h03) begin errors++; $display("FAIL arst_first_accept got %b/%h want 1/03", i4.out_valid, i4.out_data); end
        i4.in_valid = 1'b0;
        tick();
        checks++; if (i4.out_valid !== 1'b0) begin errors++; $display("FAIL arst_no_dup got %b want 0", i4.out_valid); end
    endtask

    task automatic test_sel_check();
        logic exp_err;
`ifdef MUX_PIPE_SEL_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        i3.out_ready = 1'b1;
        i3.in_data   = {5'h07, 5'h06, 5'h05};
        i3.in_sel    = 2'd1;
        i3.in_valid  = 1'b1;
        tick();
        checks++; if (i3.out_data !== 5'h06 || i3.sel_err !== 1'b0) begin errors++; $display("FAIL sel_legal got %h/%b want 06/0", i3.out_data, i3.sel_err); end
        i3.in_sel = 2'd3;
        tick();
        checks++; if (i3.sel_err !== exp_err) begin errors++; $display("FAIL sel_err_set got %b want %b", i3.sel_err, exp_err); end
        checks++; if (i3.out_valid !== 1'b1 || i3.in_ready !== 1'b1) begin errors++; $display("FAIL sel_handshake got %b/%b want 1/1", i3.out_valid, i3.in_ready); end
`ifdef MUX_PIPE_SEL_CHECK_EN
        checks++; if (i3.out_data !== 5'h00) begin errors++; $display("FAIL sel_zero_data got %h want 00", i3.out_data); end
`endif
        i3.in_sel = 2'd2;
        tick();
        checks++; if (i3.out_data !== 5'h07) begin errors++; $display("FAIL sel_after_legal got %h want 07", i3.out_data); end
        checks++; if (i3.sel_err !== exp_err) begin errors++; $display("FAIL sel_err_sticky got %b want %b", i3.sel_err, exp_err); end
        i3.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (i3.sel_err !== 1'b0) begin errors++; $display("FAIL sel_err_reset got %b want 0", i3.sel_err); end
        #2 rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        i2.in_data = '0; i2.in_sel = '0; i2.in_valid = 1'b0; i2.out_ready = 1'b0;
        i4.in_data = '0; i4.in_sel = '0; i4.in_valid = 1'b0; i4.out_ready = 1'b0;
        i3.in_data = '0; i3.in_sel = '0; i3.in_valid = 1'b0; i3.out_ready = 1'b0;
        #1;
        test_reset();
        #11 rst_n = 1'b1;
        test_basic();
        test_stall();
        test_back_to_back();
        test_async_reset();
        test_sel_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the bit width of each data channel.
REQ-002 The block SHALL have parameter CHANNELS, default 2, giving the number of selectable input channels (legal range 2..32).
REQ-003 The block SHALL have parameter SEL_W, default 1, giving the select width; SEL_W SHALL equal max(1, ceil(log2(CHANNELS))).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_data, input, WIDTH*CHANNELS bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_sel, input, SEL_W bits: channel index sampled with the beat.
REQ-008 The block SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-009 The block SHALL have port in_ready, output, 1 bit: block can accept a beat this cycle.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: registered selected channel.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data holds a beat.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream consumes the beat.
REQ-013 The block SHALL have port sel_err, output, 1 bit: sticky out-of-range select flag (see Configuration).

Function
REQ-014 Accept SHALL occur when in_valid and in_ready are both high at a rising edge; emit SHALL occur when out_valid and out_ready are both high.
REQ-015 On accept, the captured value SHALL be in_data[in_sel*WIDTH +: WIDTH], with in_sel sampled in the same cycle.
REQ-016 Storage SHALL be two entries: an output register (OUT) and a skid register (SKID), each with a valid bit.
REQ-017 in_ready SHALL equal NOT skid_valid, driven from a register with no combinational path from out_ready.
REQ-018 Latency SHALL be one cycle: a beat accepted while OUT is empty, or while OUT is being emitted with SKID empty, SHALL appear on out_data/out_valid in the next cycle.
REQ-019 A beat accepted while OUT is valid and out_ready is low SHALL be written to SKID; in_ready SHALL be low from the next cycle.
REQ-020 On emit with SKID valid, SKID SHALL move to OUT and skid_valid SHALL clear; a simultaneous accept is impossible because in_ready is low.
REQ-021 Emit and accept in the same cycle with SKID empty SHALL load the new beat into OUT, keeping out_valid high (full throughput, one beat per cycle).
REQ-022 Emit with no accept and SKID empty SHALL clear out_valid.
REQ-023 Beats SHALL leave in acceptance order; no beat SHALL be dropped or duplicated.
REQ-024 While out_valid is high and out_ready is low, out_data SHALL remain stable.
REQ-025 in_sel and in_data SHALL be ignored in cycles without accept.

Reset
REQ-026 Asserting rst_n low SHALL immediately force out_valid=0, out_data=0, skid_valid=0, SKID data=0, in_ready=1 and sel_err=0, discarding any beats in flight.
REQ-027 After rst_n deasserts, the first rising edge SHALL be able to accept a beat.

Configuration
REQ-028 The macro MUX_PIPE_SEL_CHECK_EN SHALL control out-of-range select checking.
REQ-029 With MUX_PIPE_SEL_CHECK_EN defined, a beat accepted with in_sel >= CHANNELS SHALL be captured as all-zero data and set sel_err on that edge; sel_err SHALL stay high until reset.
REQ-030 Without MUX_PIPE_SEL_CHECK_EN, sel_err SHALL be tied to 0, and the data captured for an out-of-range in_sel is undefined but SHALL NOT affect handshake behaviour.

Verification
REQ-031 WIDTH=5, CHANNELS=2, out_ready=1: accept ch0=5'h0A, ch1=5'h15 with sel=1 -> out_data=5'h15 and out_valid=1 exactly one cycle later.
REQ-032 CHANNELS=4, out_ready held low, three beats offered with sel=0,1,2 -> first two beats accepted, in_ready=0 after the second; raise out_ready -> beats emitted in order, third beat accepted the cycle after in_ready returns high.
REQ-033 Continuous in_valid and out_ready for 16 cycles with sel cycling 0..3 -> 16 beats emitted back-to-back, out_valid never drops after the first.
REQ-034 Assert rst_n low mid-stall with both entries full -> out_valid=0, in_ready=1 and out_data=0 immediately, without waiting for a clock edge.
REQ-035 CHANNELS=3 with MUX_PIPE_SEL_CHECK_EN defined, accept a beat with sel=3 -> out_data=0 and sel_err=1, which stays high through later legal beats until reset; same stimulus without the macro -> sel_err=0.
